// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the MMU cycle sequencer.
//   state_t        - sequencer states (idle, cache phases, map write, EMCL)
//   strobe_t       - bundle of active-low cycle strobes
//   STROBES_OFF    - all strobes inactive
//   SHADOW_TOP_DEFAULT / WCHIM_CYCLES_DEFAULT - parameter defaults for the top
package mmu_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StCc1  = 3'd1,
        StCc2  = 3'd2,
        StCc3  = 3'd3,
        StWch  = 3'd4,
        StEmc  = 3'd5
    } state_t;

    // Active-low strobes. DVACC_n is a held qualifier, not a strobe, so it
    // lives outside this bundle.
    typedef struct packed {
        logic rt_n;
        logic wchim_n;
        logic emcl_n;
        logic cc2_n;
        logic wca_n;
    } strobe_t;

    localparam strobe_t STROBES_OFF = '1;

    localparam logic [7:0]  SHADOW_TOP_DEFAULT   = 8'hFF;
    localparam int unsigned WCHIM_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/mmu_shadow_decode.sv
// mmu_shadow_decode: combinational qualifier compute for a memory request.
//   la        in  logical address (only the page byte la[15:8] matters)
//   shadow_en in  shadow access permitted
//   paging_on in  virtual accesses enabled
//   lshadow   out access falls in the shadow window and is permitted
//   dvacc_n   out active-low "direct (non-virtual) access" qualifier
module mmu_shadow_decode #(
    parameter logic [7:0] SHADOW_TOP = mmu_pkg::SHADOW_TOP_DEFAULT
) (
    input  logic [15:0] la,
    input  logic        shadow_en,
    input  logic        paging_on,
    output logic        lshadow,
    output logic        dvacc_n
);

    logic unused_la_low;

    assign lshadow       = shadow_en & (la[15:8] == SHADOW_TOP);
    assign dvacc_n       = paging_on;
    assign unused_la_low = ^la[7:0];

endmodule

// File: rtl/mmu_cycle_seq.sv
// mmu_cycle_seq: sequences MMU memory cycles and produces the registered
// control terms consumed by the downstream MMU control decode.
//   sysclk, sys_rst            clock, async active-high reset
//   req, req_write, la,        memory request and its qualifiers, sampled
//   sex_mode, shadow_en,       only in the accept cycle
//   paging_on
//   cache_hit                  tag compare result, sampled at the end of CC2
//   cmd_wchim, cmd_emcl        map-write and EMCL commands (priority emcl >
//                              wchim > req)
//   ready                      1 in IDLE only
//   done                       one-cycle pulse in the last cycle of an op
//   CA0, WRITE, DOUBLE,        registered qualifiers, held between ops
//   LSHADOW, DVACC_n
//   RT_n, WCHIM_n, EMCL_n,     registered active-low strobes
//   CC2_n, WCA_n
module mmu_cycle_seq #(
    parameter logic [7:0]  SHADOW_TOP   = mmu_pkg::SHADOW_TOP_DEFAULT,
    parameter int unsigned WCHIM_CYCLES = mmu_pkg::WCHIM_CYCLES_DEFAULT  // 1..15
) (
    input  logic        sysclk,
    input  logic        sys_rst,
    input  logic        req,
    input  logic        req_write,
    input  logic [15:0] la,
    input  logic        sex_mode,
    input  logic        shadow_en,
    input  logic        paging_on,
    input  logic        cache_hit,
    input  logic        cmd_wchim,
    input  logic        cmd_emcl,
    output logic        ready,
    output logic        done,
    output logic        CA0,
    output logic        WRITE,
    output logic        DOUBLE,
    output logic        LSHADOW,
    output logic        DVACC_n,
    output logic        RT_n,
    output logic        WCHIM_n,
    output logic        EMCL_n,
    output logic        CC2_n,
    output logic        WCA_n
);

    import mmu_pkg::*;

    localparam logic [3:0] WCHIM_LOAD = 4'(WCHIM_CYCLES);

    state_t     state_q;
    strobe_t    strb_q;
    logic [3:0] wcnt_q;
    logic       done_q;
    logic       ca0_q;
    logic       write_q;
    logic       double_q;
    logic       lshadow_q;
    logic       dvacc_n_q;

    logic       lshadow_d;
    logic       dvacc_n_d;
    logic       rt_n_d;
    logic       wca_n_d;

    mmu_shadow_decode #(
        .SHADOW_TOP (SHADOW_TOP)
    ) u_shadow_decode (
        .la        (la),
        .shadow_en (shadow_en),
        .paging_on (paging_on),
        .lshadow   (lshadow_d),
        .dvacc_n   (dvacc_n_d)
    );

    // The CC3 strobes are decided at the CC2->CC3 edge from the live
    // cache_hit, so the registered RT_n is itself the sampled hit result.
    always_comb begin
        rt_n_d  = ~(~write_q & ~cache_hit & ~lshadow_q);
        wca_n_d = ~(write_q & ~lshadow_q);
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            strb_q    <= STROBES_OFF;
            wcnt_q    <= 4'd0;
            done_q    <= 1'b0;
            ca0_q     <= 1'b0;
            write_q   <= 1'b0;
            double_q  <= 1'b0;
            lshadow_q <= 1'b0;
            dvacc_n_q <= 1'b1;
        end else begin
            // Strobes and done are single-state pulses; each state re-asserts
            // what it needs for the following cycle.
            strb_q <= STROBES_OFF;
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_emcl) begin
                        state_q       <= StEmc;
                        strb_q.emcl_n <= 1'b0;
                        done_q        <= 1'b1;
                        lshadow_q     <= 1'b0;
                    end else if (cmd_wchim) begin
                        state_q        <= StWch;
                        strb_q.wchim_n <= 1'b0;
                        wcnt_q         <= WCHIM_LOAD;
                        done_q         <= (WCHIM_LOAD == 4'd1);
                        lshadow_q      <= 1'b0;
                        dvacc_n_q      <= 1'b1;
                    end else if (req) begin
                        state_q   <= StCc1;
                        ca0_q     <= la[0];
                        write_q   <= req_write;
                        double_q  <= sex_mode;
                        lshadow_q <= lshadow_d;
                        dvacc_n_q <= dvacc_n_d;
                    end
                end
                StCc1: begin
                    state_q      <= StCc2;
                    strb_q.cc2_n <= 1'b0;
                end
                StCc2: begin
                    state_q     <= StCc3;
                    strb_q.rt_n <= rt_n_d;
                    strb_q.wca_n <= wca_n_d;
                    done_q      <= 1'b1;
                end
                StCc3: begin
                    state_q <= StIdle;
                end
                StWch: begin
                    if (wcnt_q <= 4'd1) begin
                        state_q <= StIdle;
                    end else begin
                        wcnt_q         <= wcnt_q - 4'd1;
                        strb_q.wchim_n <= 1'b0;
                        done_q         <= (wcnt_q == 4'd2);
                    end
                end
                StEmc: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready   = (state_q == StIdle);
    assign done    = done_q;
    assign CA0     = ca0_q;
    assign WRITE   = write_q;
    assign DOUBLE  = double_q;
    assign LSHADOW = lshadow_q;
    assign DVACC_n = dvacc_n_q;
    assign RT_n    = strb_q.rt_n;
    assign WCHIM_n = strb_q.wchim_n;
    assign EMCL_n  = strb_q.emcl_n;
    assign CC2_n   = strb_q.cc2_n;
    assign WCA_n   = strb_q.wca_n;

endmodule

// File: tb/tb_mmu_cycle_seq.sv
// tb_mmu_cycle_seq: directed self-checking bench for mmu_cycle_seq.
module tb_mmu_cycle_seq;

    logic        sysclk = 1'b0;
    logic        sys_rst;
    logic        req, req_write, sex_mode, shadow_en, paging_on, cache_hit;
    logic        cmd_wchim, cmd_emcl;
    logic [15:0] la;
    logic        ready, done, CA0, WRITE, DOUBLE, LSHADOW, DVACC_n;
    logic        RT_n, WCHIM_n, EMCL_n, CC2_n, WCA_n;

    int n_checks = 0;
    int n_err    = 0;

    always #5 sysclk = ~sysclk;

    mmu_cycle_seq dut (
        .sysclk    (sysclk),
        .sys_rst   (sys_rst),
        .req       (req),
        .req_write (req_write),
        .la        (la),
        .sex_mode  (sex_mode),
        .shadow_en (shadow_en),
        .paging_on (paging_on),
        .cache_hit (cache_hit),
        .cmd_wchim (cmd_wchim),
        .cmd_emcl  (cmd_emcl),
        .ready     (ready),
        .done      (done),
        .CA0       (CA0),
        .WRITE     (WRITE),
        .DOUBLE    (DOUBLE),
        .LSHADOW   (LSHADOW),
        .DVACC_n   (DVACC_n),
        .RT_n      (RT_n),
        .WCHIM_n   (WCHIM_n),
        .EMCL_n    (EMCL_n),
        .CC2_n     (CC2_n),
        .WCA_n     (WCA_n)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobes packed as {RT_n, WCHIM_n, EMCL_n, CC2_n, WCA_n}.
    task automatic check_strobes(input string tag, input logic [4:0] exp);
        check(tag, {11'd0, RT_n, WCHIM_n, EMCL_n, CC2_n, WCA_n}, {11'd0, exp});
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        logic [4:0] strb;
        int         lows;

        sys_rst = 1'b1;
        req = 0; req_write = 0; sex_mode = 0; shadow_en = 0; paging_on = 0;
        cache_hit = 0; cmd_wchim = 0; cmd_emcl = 0; la = 16'h0000;
        tick();
        tick();
        check_strobes("rst_strobes", 5'b11111);
        check("rst_dvacc", DVACC_n, 1'b1);
        check("rst_quals", {CA0, WRITE, DOUBLE, LSHADOW, done}, 5'b00000);
        sys_rst = 1'b0;
        tick();
        check("rst_ready", ready, 1'b1);

        // Read miss, outside shadow window.
        req = 1; req_write = 0; la = 16'h1235; shadow_en = 1; paging_on = 1; cache_hit = 0;
        check("rm_c1_ready", ready, 1'b1);
        tick();
        req = 0; la = 16'hFF00; paging_on = 0; sex_mode = 1;  // must not disturb op
        check("rm_c2_quals", {CA0, LSHADOW, DVACC_n, WRITE, DOUBLE}, 5'b10100);
        check("rm_c2_ready", ready, 1'b0);
        check_strobes("rm_c2_strobes", 5'b11111);
        tick();
        check_strobes("rm_c3_cc2", 5'b11101);
        tick();
        check_strobes("rm_c4_rt", 5'b01111);
        check("rm_c4_done", done, 1'b1);
        tick();
        check("rm_c5_ready", ready, 1'b1);
        check("rm_c5_done", done, 1'b0);
        check_strobes("rm_c5_strobes", 5'b11111);
        check("rm_c5_hold", {CA0, DVACC_n}, 2'b11);

        // Shadow disabled, read hit.
        req = 1; req_write = 0; sex_mode = 0; la = 16'hFF10; shadow_en = 0; paging_on = 0;
        cache_hit = 1;
        tick();
        req = 0;
        check("sd_quals", {LSHADOW, DVACC_n}, 2'b00);
        tick();
        tick();
        check_strobes("sd_hit_no_rt", 5'b11111);
        check("sd_done", done, 1'b1);
        tick();

        // Non-shadow write: WCA_n strobes in CC3.
        req = 1; req_write = 1; la = 16'h1000; shadow_en = 1; paging_on = 1; cache_hit = 0;
        tick();
        req = 0;
        check("nw_quals", {WRITE, LSHADOW, CA0}, 3'b100);
        tick();
        tick();
        check_strobes("nw_wca", 5'b11110);
        tick();

        // Shadow write in SEX mode: neither RT_n nor WCA_n fires.
        req = 1; req_write = 1; sex_mode = 1; la = 16'hFF10; shadow_en = 1; paging_on = 0;
        tick();
        req = 0;
        check("sw_quals", {LSHADOW, DOUBLE, WRITE, CA0, DVACC_n}, 5'b11100);
        tick();
        check_strobes("sw_c3", 5'b11101);
        tick();
        check_strobes("sw_c4", 5'b11111);
        check("sw_done", done, 1'b1);
        tick();
        check("sw_ready", ready, 1'b1);

        // Priority: EMCL, then held WCHIM, then held req.
        cmd_emcl = 1; cmd_wchim = 1; req = 1; req_write = 0; sex_mode = 0;
        la = 16'h0001; shadow_en = 1; paging_on = 1;
        tick();
        cmd_emcl = 0;
        check_strobes("pr_emcl", 5'b11011);
        check("pr_emcl_done", done, 1'b1);
        check("pr_emcl_lshadow", LSHADOW, 1'b0);
        check("pr_emcl_dvacc_hold", DVACC_n, 1'b0);
        tick();
        check("pr_idle1_ready", ready, 1'b1);
        check_strobes("pr_idle1", 5'b11111);
        tick();
        cmd_wchim = 0;
        check_strobes("pr_wch1", 5'b10111);
        check("pr_wch1_q", {LSHADOW, DVACC_n, done}, 3'b010);
        tick();
        check_strobes("pr_wch2", 5'b10111);
        check("pr_wch2_done", done, 1'b1);
        tick();
        check_strobes("pr_idle2", 5'b11111);
        check("pr_idle2_ready", ready, 1'b1);
        tick();
        req = 0;
        check("pr_req_acc", {ready, CA0}, 2'b01);
        tick();
        tick();
        tick();

        // Back-to-back reads with req held high: CC2_n every 4th cycle.
        req = 1; req_write = 0; la = 16'h0004; shadow_en = 0; paging_on = 1; cache_hit = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            strb = {RT_n, WCHIM_n, EMCL_n, CC2_n, WCA_n};
            lows = 0;
            for (int b = 0; b < 5; b++) if (strb[b] == 1'b0) lows++;
            check("bb_cc2", CC2_n, (i % 4 == 2) ? 1'b0 : 1'b1);
            check("bb_rt", RT_n, (i % 4 == 3) ? 1'b0 : 1'b1);
            check("bb_excl", 16'(lows <= 1), 16'd1);
        end
        req = 0;
        tick();
        tick();
        tick();
        tick();
        check("bb_idle", ready, 1'b1);

        // Async reset mid-CC2 of a shadow write.
        req = 1; req_write = 1; la = 16'hFF00; shadow_en = 1; paging_on = 1;
        tick();
        req = 0;
        tick();
        check("rs_cc2_low", {CC2_n, LSHADOW}, 2'b01);
        #2;
        sys_rst = 1'b1;
        #1;
        check_strobes("rs_strobes", 5'b11111);
        check("rs_quals", {LSHADOW, WRITE, done, DVACC_n}, 4'b0001);
        #2;
        sys_rst = 1'b0;
        tick();
        check("rs_ready", ready, 1'b1);
        tick();
        check("rs_still_idle", {ready, CC2_n}, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
